// File: rtl/cic_comb.sv
// cic_comb: N-stage CIC comb (y = x - x[n-M], wrapping), then scaling to OW bits.
// Ports: i_clk, i_rst (async, active-high), i_data/i_ready (decimated input with strobe),
//        o_data/o_ready (scaled output with strobe, N+1 cycles after i_ready).
// Define CIC_COMB_ROUND_EN to round half toward +inf before dropping the W-OW LSBs.
module cic_comb #(
  parameter int W  = 5,
  parameter int N  = 3,
  parameter int M  = 1,
  parameter int OW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [W-1:0]  i_data,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic          o_ready
);
  // sx/sv[k] is the data/valid entering stage k; sx/sv[N] feeds the output register.
  logic [W-1:0] sx [N+1];
  logic [N:0]   sv;
  logic [W-1:0] sc;
  assign sx[0] = i_data;
  assign sv[0] = i_ready;
  for (genvar k = 0; k < N; k++) begin : g_st
    logic [W-1:0] dl [M];
    logic [W-1:0] r;
    logic         v;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int i = 0; i < M; i++) dl[i] <= '0;
        r <= '0;
        v <= 1'b0;
      end else begin
        v <= sv[k];
        if (sv[k]) begin
          r     <= sx[k] - dl[M-1];
          dl[0] <= sx[k];
          for (int i = 1; i < M; i++) dl[i] <= dl[i-1];
        end
      end
    end
    assign sx[k+1] = r;
    assign sv[k+1] = v;
  end
`ifdef CIC_COMB_ROUND_EN
  if (OW < W) begin : g_rnd
    assign sc = sx[N] + (W'(1) << (W - OW - 1));
  end else begin : g_pass
    assign sc = sx[N];
  end
`else
  assign sc = sx[N];
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data  <= '0;
      o_ready <= 1'b0;
    end else begin
      o_ready <= sv[N];
      if (sv[N]) o_data <= sc[W-1 -: OW];
    end
  end
endmodule
